axis_mux: RTL and testbench

//  Frame-aware AXI4-Stream N:1 multiplexer; the merging counterpart of axis_demux.
//  On the first valid beat of the input picked by 'select', it locks to that input and forwards the whole frame.
//  The frame ends with tlast. The output has a registered 2-entry skid buffer.

---
 rtl/axis_mux_if.sv | 31 +++
 rtl/axis_mux.sv | 167 ++++++++++++++++
 tb/tb_axis_mux.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_mux_if.sv
// AXI4-Stream bundle carrying COUNT parallel lanes (COUNT=1 for a single stream).
// Modports:
//   master - drives tdata/tkeep/tvalid/tlast/tid/tdest/tuser, receives tready
//   slave  - receives the payload, drives tready
interface axis_mux_if #(
    parameter int unsigned COUNT      = 1,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned KEEP_WIDTH = 1,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned DEST_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 1
);
    logic [COUNT*DATA_WIDTH-1:0] tdata;
    logic [COUNT*KEEP_WIDTH-1:0] tkeep;
    logic [COUNT-1:0]            tvalid;
    logic [COUNT-1:0]            tready;
    logic [COUNT-1:0]            tlast;
    logic [COUNT*ID_WIDTH-1:0]   tid;
    logic [COUNT*DEST_WIDTH-1:0] tdest;
    logic [COUNT*USER_WIDTH-1:0] tuser;

    modport master (
        output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axis_mux.sv
// Frame-aware AXI4-Stream N:1 multiplexer with a registered 2-entry output skid buffer.
// Locks to the input named by 'select' on its first valid beat and forwards the
// whole frame (up to tlast) before re-arbitrating.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   s_axis    - S_COUNT input lanes (slave view, lane i at [i*W +: W])
//   m_axis    - merged output stream (master view, one lane)
//   enable    - 0 gates off all input ready without dropping the frame lock
//   select    - lane to lock on at the next frame start
module axis_mux #(
    parameter int unsigned S_COUNT     = 4,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int unsigned KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter bit          ID_ENABLE   = 1'b0,
    parameter int unsigned ID_WIDTH    = 8,
    parameter bit          DEST_ENABLE = 1'b0,
    parameter int unsigned DEST_WIDTH  = 8,
    parameter bit          USER_ENABLE = 1'b1,
    parameter int unsigned USER_WIDTH  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    axis_mux_if.slave                  s_axis,
    axis_mux_if.master                 m_axis,
    input  logic                       enable,
    input  logic [$clog2(S_COUNT)-1:0] select
);
    localparam int unsigned SEL_WIDTH  = $clog2(S_COUNT);
    localparam int unsigned BEAT_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

    logic [SEL_WIDTH-1:0]  select_reg, select_next;
    logic                  frame_reg, frame_next;
    logic [S_COUNT-1:0]    s_axis_tready_reg, s_axis_tready_next;

    logic                  m_tvalid_reg, m_tvalid_next;
    logic                  temp_tvalid_reg, temp_tvalid_next;
    logic                  m_tready_int_reg, m_tready_int_early;
    logic [BEAT_WIDTH-1:0] m_beat_reg, temp_beat_reg, beat_int;
    logic                  store_int_to_out, store_int_to_temp, store_temp_to_out;

    logic                  cur_tvalid, cur_tready, cur_tlast, sel_tvalid, m_tvalid_int;

    logic [DATA_WIDTH-1:0] o_data;
    logic [KEEP_WIDTH-1:0] o_keep;
    logic                  o_last;
    logic [ID_WIDTH-1:0]   o_id;
    logic [DEST_WIDTH-1:0] o_dest;
    logic [USER_WIDTH-1:0] o_user;

    assign s_axis.tready = s_axis_tready_reg & {S_COUNT{enable}};

    // Lane mux for the locked input, plus valid of the lane named by 'select'.
    // An out-of-range select matches no lane, so it can never lock.
    always_comb begin
        cur_tvalid = 1'b0;
        cur_tready = 1'b0;
        cur_tlast  = 1'b0;
        sel_tvalid = 1'b0;
        beat_int   = '0;
        for (int i = 0; i < int'(S_COUNT); i++) begin
            if (select_reg == SEL_WIDTH'(i)) begin
                cur_tvalid = s_axis.tvalid[i];
                cur_tready = s_axis.tready[i];
                cur_tlast  = s_axis.tlast[i];
                beat_int   = {s_axis.tdata[i*DATA_WIDTH +: DATA_WIDTH],
                              s_axis.tkeep[i*KEEP_WIDTH +: KEEP_WIDTH],
                              s_axis.tlast[i],
                              s_axis.tid[i*ID_WIDTH +: ID_WIDTH],
                              s_axis.tdest[i*DEST_WIDTH +: DEST_WIDTH],
                              s_axis.tuser[i*USER_WIDTH +: USER_WIDTH]};
            end
            if (select == SEL_WIDTH'(i)) begin
                sel_tvalid = s_axis.tvalid[i];
            end
        end
    end

    assign m_tvalid_int = cur_tvalid & cur_tready;

    // Skid buffer can take a beat next cycle unless it would overflow.
    assign m_tready_int_early = m_axis.tready | (~temp_tvalid_reg & (~m_tvalid_reg | ~m_tvalid_int));

    // Frame lock next state; lock is only evaluated while idle, so tlast forces a 1-cycle gap.
    always_comb begin
        select_next        = select_reg;
        frame_next         = frame_reg;
        s_axis_tready_next = '0;

        if (m_tvalid_int && cur_tlast) begin
            frame_next = 1'b0;
        end

        if (!frame_reg && enable && sel_tvalid) begin
            select_next = select;
            frame_next  = 1'b1;
        end

        for (int i = 0; i < int'(S_COUNT); i++) begin
            s_axis_tready_next[i] = frame_next && m_tready_int_early && (select_next == SEL_WIDTH'(i));
        end
    end

    // Skid buffer steering: int->out, int->temp, or temp->out.
    always_comb begin
        m_tvalid_next     = m_tvalid_reg;
        temp_tvalid_next  = temp_tvalid_reg;
        store_int_to_out  = 1'b0;
        store_int_to_temp = 1'b0;
        store_temp_to_out = 1'b0;

        if (m_tready_int_reg) begin
            if (m_axis.tready || !m_tvalid_reg) begin
                m_tvalid_next    = m_tvalid_int;
                store_int_to_out = 1'b1;
            end else begin
                temp_tvalid_next  = m_tvalid_int;
                store_int_to_temp = 1'b1;
            end
        end else if (m_axis.tready) begin
            m_tvalid_next     = temp_tvalid_reg;
            temp_tvalid_next  = 1'b0;
            store_temp_to_out = 1'b1;
        end
    end

    // Control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            select_reg        <= '0;
            frame_reg         <= 1'b0;
            s_axis_tready_reg <= '0;
            m_tvalid_reg      <= 1'b0;
            temp_tvalid_reg   <= 1'b0;
            m_tready_int_reg  <= 1'b0;
        end else begin
            select_reg        <= select_next;
            frame_reg         <= frame_next;
            s_axis_tready_reg <= s_axis_tready_next;
            m_tvalid_reg      <= m_tvalid_next;
            temp_tvalid_reg   <= temp_tvalid_next;
            m_tready_int_reg  <= m_tready_int_early;
        end
    end

    // Payload registers need no reset; they are qualified by the valid flags.
    always_ff @(posedge clk) begin
        if (store_int_to_out) begin
            m_beat_reg <= beat_int;
        end else if (store_temp_to_out) begin
            m_beat_reg <= temp_beat_reg;
        end
        if (store_int_to_temp) begin
            temp_beat_reg <= beat_int;
        end
    end

    assign {o_data, o_keep, o_last, o_id, o_dest, o_user} = m_beat_reg;

    assign m_axis.tvalid = m_tvalid_reg;
    assign m_axis.tdata  = o_data;
    assign m_axis.tlast  = o_last;
    assign m_axis.tkeep  = KEEP_ENABLE ? o_keep : {KEEP_WIDTH{1'b1}};
    assign m_axis.tid    = ID_ENABLE   ? o_id   : '0;
    assign m_axis.tdest  = DEST_ENABLE ? o_dest : '0;
    assign m_axis.tuser  = USER_ENABLE ? o_user : '0;
endmodule

// File: tb/tb_axis_mux.sv
// Directed bench for axis_mux: 4 lanes, 8-bit data, tkeep and tuser propagated,
// tid/tdest disabled (must read back as zero).
module tb_axis_mux;
    typedef struct packed {
        logic [7:0] data;
        logic       keep;
        logic       last;
        logic [7:0] id;
        logic [7:0] dest;
        logic       user;
    } beat_t;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [1:0] select;

    int errors = 0;
    int checks = 0;

    beat_t src_q [4][$];
    beat_t out_q [$];

    axis_mux_if #(.COUNT(4), .DATA_WIDTH(8), .KEEP_WIDTH(1), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)) s_if ();
    axis_mux_if #(.COUNT(1), .DATA_WIDTH(8), .KEEP_WIDTH(1), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)) m_if ();

    axis_mux #(
        .S_COUNT(4), .DATA_WIDTH(8), .KEEP_ENABLE(1'b1), .KEEP_WIDTH(1),
        .ID_ENABLE(1'b0), .ID_WIDTH(8), .DEST_ENABLE(1'b0), .DEST_WIDTH(8),
        .USER_ENABLE(1'b1), .USER_WIDTH(1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s_axis (s_if.slave),
        .m_axis (m_if.master),
        .enable (enable),
        .select (select)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic beat_t mk(input logic [7:0] d, input logic k, input logic l, input logic u);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        b.id   = 8'h5A;
        b.dest = 8'h3C;
        b.user = u;
        return b;
    endfunction

    // Put the head of each source queue on its lane.
    task automatic present_heads();
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() > 0) begin
                s_if.tvalid[i]        = 1'b1;
                s_if.tdata[i*8 +: 8]  = src_q[i][0].data;
                s_if.tkeep[i]         = src_q[i][0].keep;
                s_if.tlast[i]         = src_q[i][0].last;
                s_if.tid[i*8 +: 8]    = src_q[i][0].id;
                s_if.tdest[i*8 +: 8]  = src_q[i][0].dest;
                s_if.tuser[i]         = src_q[i][0].user;
            end else begin
                s_if.tvalid[i]        = 1'b0;
                s_if.tdata[i*8 +: 8]  = 8'h00;
                s_if.tkeep[i]         = 1'b0;
                s_if.tlast[i]         = 1'b0;
                s_if.tid[i*8 +: 8]    = 8'h00;
                s_if.tdest[i*8 +: 8]  = 8'h00;
                s_if.tuser[i]         = 1'b0;
            end
        end
    endtask

    // Source driver: a lane that handshook at the edge advances to its next beat.
    initial begin : driver
        logic [3:0] hs;
        beat_t      dummy;
        forever begin
            @(negedge clk);
            hs = s_if.tvalid & s_if.tready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (hs[i] && src_q[i].size() > 0) dummy = src_q[i].pop_front();
            end
            present_heads();
        end
    end

    // Output monitor: logs every beat that handshakes at the following edge.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (m_if.tvalid[0] && m_if.tready[0]) begin
                out_q.push_back('{data: m_if.tdata, keep: m_if.tkeep[0], last: m_if.tlast[0],
                                  id: m_if.tid, dest: m_if.tdest, user: m_if.tuser[0]});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_out(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (out_q.size() >= n) break;
            cyc();
        end
        if (out_q.size() >= n) ok = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        select = 2'd0;
        m_if.tready = 1'b1;
        present_heads();
        repeat (3) cyc();
        @(negedge clk);
        checks++;
        if (m_if.tvalid[0] !== 1'b0) begin
            errors++; $display("FAIL reset_m_tvalid: got %b required 0", m_if.tvalid[0]);
        end
        checks++;
        if (s_if.tready !== 4'b0000) begin
            errors++; $display("FAIL reset_s_tready: got %b required 0000", s_if.tready);
        end
        cyc();
        rst = 1'b0;
        cyc();
        @(negedge clk);
        checks++;
        if (m_if.tvalid[0] !== 1'b0 || s_if.tready !== 4'b0000) begin
            errors++; $display("FAIL idle_after_reset: got tvalid=%b tready=%b required 0/0000",
                               m_if.tvalid[0], s_if.tready);
        end
    endtask

    task automatic test_single_frame();
        logic [3:0] seen;
        bit ok;
        out_q.delete();
        seen = 4'b0000;
        cyc();
        select = 2'd2;
        for (int k = 0; k < 4; k++) src_q[2].push_back(mk(8'hA0 + 8'(k), 1'b1, k == 3, 1'b0));
        present_heads();
        @(negedge clk);
        checks++;
        if (s_if.tready !== 4'b0000) begin
            errors++; $display("FAIL lock_cycle_ready: got %b required 0000", s_if.tready);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (s_if.tready !== 4'b0100 || m_if.tvalid[0] !== 1'b0) begin
            errors++; $display("FAIL first_accept: got tready=%b tvalid=%b required 0100/0",
                               s_if.tready, m_if.tvalid[0]);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (m_if.tvalid[0] !== 1'b1 || m_if.tdata !== 8'hA0) begin
            errors++; $display("FAIL first_out_latency: got tvalid=%b data=%h required 1/a0",
                               m_if.tvalid[0], m_if.tdata);
        end
        for (int j = 0; j < 6; j++) begin
            cyc();
            @(negedge clk);
            seen = seen | s_if.tready;
            if (j == 2) begin
                checks++;
                if (s_if.tready !== 4'b0000) begin
                    errors++; $display("FAIL idle_after_tlast: got %b required 0000", s_if.tready);
                end
            end
        end
        checks++;
        if ((seen & 4'b1011) !== 4'b0000) begin
            errors++; $display("FAIL only_lane2_ready: got seen=%b required 0x00 outside lane 2", seen);
        end
        wait_out(4, 10, ok);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k >= out_q.size()) begin
                errors++; $display("FAIL t1_beat%0d: got missing required %h", k, 8'hA0 + 8'(k));
            end else if (out_q[k].data !== 8'hA0 + 8'(k) || out_q[k].last !== 1'(k == 3)) begin
                errors++; $display("FAIL t1_beat%0d: got data=%h last=%b required %h/%b", k,
                                   out_q[k].data, out_q[k].last, 8'hA0 + 8'(k), 1'(k == 3));
            end
        end
        checks++;
        if (out_q.size() != 4) begin
            errors++; $display("FAIL t1_count: got %0d required 4", out_q.size());
        end
    endtask

    task automatic test_select_switch();
        logic [7:0] exp_d [6];
        bit ok;
        exp_d = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h31};
        out_q.delete();
        cyc();
        select = 2'd1;
        for (int k = 0; k < 4; k++) src_q[1].push_back(mk(8'h20 + 8'(k), 1'b1, k == 3, 1'b0));
        present_heads();
        cyc();
        cyc();
        select = 2'd3;
        src_q[3].push_back(mk(8'h30, 1'b1, 1'b0, 1'b0));
        src_q[3].push_back(mk(8'h31, 1'b1, 1'b1, 1'b0));
        present_heads();
        @(negedge clk);
        checks++;
        if (s_if.tready !== 4'b0010) begin
            errors++; $display("FAIL lock_held_on_switch: got %b required 0010", s_if.tready);
        end
        wait_out(6, 40, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL t2_timeout: got %0d beats required 6", out_q.size());
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (k >= out_q.size() || out_q[k].data !== exp_d[k] || out_q[k].last !== 1'(k == 3 || k == 5)) begin
                errors++; $display("FAIL t2_beat%0d: got %h required %h", k,
                                   (k < out_q.size()) ? out_q[k].data : 8'hxx, exp_d[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] prev_data;
        bit prev_stall;
        bit ok;
        out_q.delete();
        prev_stall = 1'b0;
        prev_data = 8'h00;
        cyc();
        select = 2'd0;
        for (int k = 0; k < 8; k++) src_q[0].push_back(mk(8'h10 + 8'(k), 1'b1, k == 7, 1'b0));
        present_heads();
        for (int c = 0; c < 40 && out_q.size() < 8; c++) begin
            cyc();
            m_if.tready[0] = ~m_if.tready[0];
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (m_if.tvalid[0] !== 1'b1 || m_if.tdata !== prev_data) begin
                    errors++; $display("FAIL stall_stable: got tvalid=%b data=%h required 1/%h",
                                       m_if.tvalid[0], m_if.tdata, prev_data);
                end
            end
            prev_stall = m_if.tvalid[0] && !m_if.tready[0];
            prev_data = m_if.tdata;
        end
        cyc();
        m_if.tready[0] = 1'b1;
        wait_out(8, 20, ok);
        repeat (3) cyc();
        checks++;
        if (out_q.size() != 8) begin
            errors++; $display("FAIL t3_count: got %0d required 8", out_q.size());
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (k >= out_q.size() || out_q[k].data !== 8'h10 + 8'(k) || out_q[k].last !== 1'(k == 7)) begin
                errors++; $display("FAIL t3_beat%0d: got %h required %h", k,
                                   (k < out_q.size()) ? out_q[k].data : 8'hxx, 8'h10 + 8'(k));
            end
        end
    endtask

    task automatic test_enable_pause();
        logic [7:0] exp_d [7];
        logic       exp_k [7];
        logic       exp_l [7];
        bit ok;
        exp_d = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h50};
        exp_k = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        out_q.delete();
        cyc();
        select = 2'd2;
        for (int k = 0; k < 6; k++) src_q[2].push_back(mk(exp_d[k], exp_k[k], exp_l[k], 1'b0));
        present_heads();
        cyc();
        cyc();
        for (int p = 0; p < 3; p++) begin
            cyc();
            enable = 1'b0;
            if (p == 0) begin
                select = 2'd0;
                src_q[0].push_back(mk(8'h50, 1'b1, 1'b1, 1'b1));
                present_heads();
            end
            @(negedge clk);
            checks++;
            if (s_if.tready !== 4'b0000) begin
                errors++; $display("FAIL pause_ready%0d: got %b required 0000", p, s_if.tready);
            end
        end
        cyc();
        enable = 1'b1;
        wait_out(7, 40, ok);
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (k >= out_q.size() || out_q[k].data !== exp_d[k] || out_q[k].keep !== exp_k[k] ||
                out_q[k].last !== exp_l[k]) begin
                errors++; $display("FAIL t4_beat%0d: got %h required data=%h keep=%b last=%b", k,
                                   (k < out_q.size()) ? out_q[k] : '0, exp_d[k], exp_k[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [3];
        logic       exp_u [3];
        bit ok;
        exp_d = '{8'h61, 8'h62, 8'h63};
        exp_u = '{1'b1, 1'b0, 1'b1};
        out_q.delete();
        cyc();
        select = 2'd0;
        src_q[0].push_back(mk(8'h61, 1'b1, 1'b1, 1'b1));
        src_q[0].push_back(mk(8'h63, 1'b1, 1'b1, 1'b1));
        src_q[1].push_back(mk(8'h62, 1'b1, 1'b1, 1'b0));
        present_heads();
        for (int c = 0; c < 20 && src_q[0].size() != 1; c++) cyc();
        select = 2'd1;
        for (int c = 0; c < 20 && src_q[1].size() != 0; c++) cyc();
        select = 2'd0;
        wait_out(3, 20, ok);
        repeat (3) cyc();
        checks++;
        if (out_q.size() != 3) begin
            errors++; $display("FAIL t5_count: got %0d required 3", out_q.size());
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (k >= out_q.size() || out_q[k].data !== exp_d[k] || out_q[k].user !== exp_u[k] ||
                out_q[k].last !== 1'b1 || out_q[k].id !== 8'h00 || out_q[k].dest !== 8'h00) begin
                errors++; $display("FAIL t5_beat%0d: got %h required data=%h user=%b last=1 id=0 dest=0", k,
                                   (k < out_q.size()) ? out_q[k] : '0, exp_d[k], exp_u[k]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        out_q.delete();
        cyc();
        select = 2'd3;
        for (int k = 0; k < 4; k++) src_q[3].push_back(mk(8'h70 + 8'(k), 1'b1, k == 3, 1'b0));
        present_heads();
        cyc();
        cyc();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (m_if.tvalid[0] !== 1'b1) begin
            errors++; $display("FAIL pre_reset_valid: got %b required 1", m_if.tvalid[0]);
        end
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) src_q[i].delete();
        present_heads();
        out_q.delete();
        @(negedge clk);
        checks++;
        if (m_if.tvalid[0] !== 1'b0 || s_if.tready !== 4'b0000) begin
            errors++; $display("FAIL reset_mid_frame: got tvalid=%b tready=%b required 0/0000",
                               m_if.tvalid[0], s_if.tready);
        end
        cyc();
        src_q[3].push_back(mk(8'h80, 1'b1, 1'b0, 1'b1));
        src_q[3].push_back(mk(8'h81, 1'b1, 1'b1, 1'b0));
        present_heads();
        wait_out(2, 20, ok);
        repeat (3) cyc();
        checks++;
        if (out_q.size() != 2 || out_q[0].data !== 8'h80 || out_q[1].data !== 8'h81 ||
            out_q[0].last !== 1'b0 || out_q[1].last !== 1'b1) begin
            errors++; $display("FAIL relock_after_reset: got %0d beats first=%h required 2 beats 80,81",
                               out_q.size(), (out_q.size() > 0) ? out_q[0].data : 8'hxx);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_select_switch();
        test_backpressure();
        test_enable_pause();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
